// File: rtl/conv1d_seq_pkg.sv
// conv1d_seq_pkg: shared state encoding and default widths for the qalc sequencer.
package conv1d_seq_pkg;
  localparam int DEF_POS_W = 8;
  localparam int DEF_CH_W = 4;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_TMO_W = 12;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, ADV, FIN} seq_state_t;
endpackage

// File: rtl/conv1d_nest_cnt.sv
// conv1d_nest_cnt: two-level counter, channel inner loop and position outer loop.
module conv1d_nest_cnt #(
  parameter int POS_W = 8,
  parameter int CH_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CH_W-1:0]  ch_lim,
  input  logic [POS_W-1:0] pos_lim,
  output logic [CH_W-1:0]  ch,
  output logic [POS_W-1:0] pos,
  output logic             last
);
  logic [CH_W-1:0] ch_q, ch_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic ch_wrap;
  always_comb begin
    ch_wrap = ch_q == ch_lim - CH_W'(1);
    last = ch_wrap && pos_q == pos_lim - POS_W'(1);
    ch_d = clr ? '0 : inc ? (ch_wrap ? '0 : ch_q + CH_W'(1)) : ch_q;
    pos_d = clr ? '0 : (inc && ch_wrap) ? pos_q + POS_W'(1) : pos_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= '0;
      pos_q <= '0;
    end else begin
      ch_q <= ch_d;
      pos_q <= pos_d;
    end
  end
  assign ch = ch_q;
  assign pos = pos_q;
endmodule

// File: rtl/conv1d_qalc_sequencer.sv
// conv1d_qalc_sequencer: walks every (position, channel) pair, firing one qalc request and one result write per pair.
module conv1d_qalc_sequencer
  import conv1d_seq_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int CH_W = DEF_CH_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              clear,
  input  logic [POS_W-1:0]  out_len,
  input  logic [CH_W-1:0]   num_ch,
  input  logic              done_qalc,
  output logic              start_qalc,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic              err_tmo
);
  seq_state_t state_q, state_d;
  logic [POS_W-1:0] len_q, len_d, pos;
  logic [CH_W-1:0] nch_q, nch_d, ch;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic done_q, done_d, err_q, err_d, last, cnt_clr, tmo;
  conv1d_nest_cnt #(.POS_W(POS_W), .CH_W(CH_W)) u_cnt (
    .clk(clk), .rst(reset), .clr(cnt_clr), .inc(state_q == ADV),
    .ch_lim(nch_q), .pos_lim(len_q), .ch(ch), .pos(pos), .last(last)
  );
  // the watchdog fires on the WAIT cycle that would bring it to all-ones
  assign tmo = state_q == WAIT && !done_qalc && wdog_q == {{(TMO_W-1){1'b1}}, 1'b0};
  always_ff @(posedge clk) state_q <= (reset || abort) ? IDLE : state_d;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = !start ? IDLE : (out_len == '0 || num_ch == '0) ? FIN : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  state_d = done_qalc ? STORE : tmo ? FIN : WAIT;
      STORE: state_d = ADV;
      ADV:   state_d = last ? FIN : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    start_qalc = state_q == ISSUE;
    res_we = state_q == STORE;
    busy = state_q != IDLE && state_q != FIN;
  end
  always_comb begin
    len_d = len_q;
    nch_d = nch_q;
    addr_d = addr_q;
    wdog_d = wdog_q;
    done_d = done_q;
    err_d = err_q;
    cnt_clr = 1'b0;
    if (state_q == IDLE && (start || clear)) begin
      done_d = 1'b0;
      err_d = 1'b0;
    end
    if (state_q == IDLE && start) begin
      len_d = out_len;
      nch_d = num_ch;
      addr_d = '0;
      cnt_clr = 1'b1;
    end
    if (state_q == ISSUE) wdog_d = '0;
    if (state_q == WAIT && !done_qalc) wdog_d = wdog_q + TMO_W'(1);
    if (tmo) err_d = 1'b1;
    if (state_q == ADV) addr_d = addr_q + ADDR_W'(1);
    if (state_q == FIN) done_d = 1'b1;
    if (abort) begin
      addr_d = '0;
      wdog_d = '0;
      cnt_clr = 1'b1;
      done_d = done_q;
      err_d = err_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      nch_q <= '0;
      addr_q <= '0;
      wdog_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      len_q <= len_d;
      nch_q <= nch_d;
      addr_q <= addr_d;
      wdog_q <= wdog_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // addr must always equal the linear index of the (pos, ch) pair being retired
  assert property (@(posedge clk) disable iff (reset)
    state_q == ADV |-> addr_q == ADDR_W'(pos) * ADDR_W'(nch_q) + ADDR_W'(ch));
  assign res_addr = addr_q;
  assign done = done_q;
  assign err_tmo = err_q;
endmodule

// File: tb/tb_conv1d_qalc_sequencer.sv
// tb_conv1d_qalc_sequencer: directed runs with a qalc responder model and a result-write scoreboard.
module tb_conv1d_qalc_sequencer;
  localparam int POS_W = 8, CH_W = 4, ADDR_W = 12, TMO_W = 12;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, clear = 1'b0, done_qalc = 1'b0;
  logic [POS_W-1:0] out_len = '0;
  logic [CH_W-1:0] num_ch = '0;
  logic start_qalc, res_we, busy, done, err_tmo;
  logic [ADDR_W-1:0] res_addr;
  int n_tests = 0, n_fail = 0, cyc = 0, nstart = 0, lat = 5, cd = 0, done_cyc = -100, t0 = 0, n0 = 0;
  bit qalc_on = 1'b1, glitch = 1'b0, pend_next = 1'b0;
  int exp_q[$];

  conv1d_qalc_sequencer #(.POS_W(POS_W), .CH_W(CH_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .clear(clear),
    .out_len(out_len), .num_ch(num_ch), .done_qalc(done_qalc),
    .start_qalc(start_qalc), .res_we(res_we), .res_addr(res_addr),
    .busy(busy), .done(done), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int len, int nch);
    out_len = POS_W'(len);
    num_ch = CH_W'(nch);
    start = 1'b1;
    pend_next = 1'b0;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  task automatic wait_done(string name, int lim);
    int k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    chk({name, "_done_in_time"}, 32'(k < lim), 1);
  endtask

  // qalc responder: done_qalc lat cycles after each start_qalc, optional spurious pulse in ISSUE
  always @(negedge clk) begin
    done_qalc = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        done_qalc = 1'b1;
        done_cyc = cyc;
      end
    end
    if (start_qalc) begin
      nstart++;
      if (pend_next) begin
        chk("next_start_latency", cyc - done_cyc, 3);
        pend_next = 1'b0;
      end
      if (qalc_on) cd = lat;
      if (glitch) done_qalc = 1'b1;
    end
  end

  // scoreboard monitor: every result write must match the oldest expected address
  always @(negedge clk) begin
    if (res_we) begin
      chk("res_addr", 32'(res_addr), exp_q.size() > 0 ? exp_q.pop_front() : 'x);
      chk("res_we_latency", cyc - done_cyc, 1);
      pend_next = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    repeat (3) tick();
    chk("rst_start_qalc", start_qalc, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_tmo", err_tmo, 0);
    chk("rst_res_addr", res_addr, 0);
    reset = 1'b0;
    tick();

    // T1: 2 positions x 3 channels
    push_run(6);
    n0 = nstart;
    go(2, 3);
    @(negedge clk);
    chk("t1_start_qalc_at_t1", start_qalc, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 300);
    chk("t1_done", done, 1);
    chk("t1_err_tmo", err_tmo, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_pulses", nstart - n0, 6);
    chk("t1_queue_empty", exp_q.size(), 0);

    // T2: zero output length
    tick();
    n0 = nstart;
    go(0, 4);
    chk("t2_done_cleared", done, 0);
    chk("t2_busy_t1", busy, 0);
    tick();
    chk("t2_done_t2", done, 1);
    chk("t2_busy_t2", busy, 0);
    repeat (3) tick();
    chk("t2_pulses", nstart - n0, 0);

    // T3: watchdog expiry
    qalc_on = 1'b0;
    n0 = nstart;
    go(1, 1);
    k = 0;
    while (!err_tmo && k < 5000) begin
      tick();
      k++;
    end
    chk("t3_err_tmo_cycle", cyc - t0, 4097);
    tick();
    chk("t3_done", done, 1);
    chk("t3_err_tmo", err_tmo, 1);
    chk("t3_pulses", nstart - n0, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clear_done", done, 0);
    chk("t3_clear_err", err_tmo, 0);
    qalc_on = 1'b1;

    // T4: abort during the second WAIT, then a clean run
    push_run(1);
    n0 = nstart;
    go(2, 2);
    k = 0;
    while (nstart - n0 < 2 && k < 100) begin
      tick();
      k++;
    end
    chk("t4_second_issue_seen", 32'(k < 100), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy_after_abort", busy, 0);
    chk("t4_done_after_abort", done, 0);
    repeat (10) tick();
    chk("t4_late_done_dropped", busy, 0);
    chk("t4_queue_empty", exp_q.size(), 0);
    push_run(2);
    n0 = nstart;
    go(1, 2);
    wait_done("t4b", 200);
    chk("t4b_pulses", nstart - n0, 2);
    chk("t4b_queue_empty", exp_q.size(), 0);

    // T5: stray starts, mid-run length change and done_qalc in ISSUE
    glitch = 1'b1;
    push_run(6);
    n0 = nstart;
    go(2, 3);
    k = 0;
    while (!done && k < 300) begin
      start = (k % 5 == 2);
      if (k == 10) begin
        out_len = 9;
        num_ch = 1;
      end
      tick();
      k++;
    end
    start = 1'b0;
    glitch = 1'b0;
    chk("t5_done_in_time", 32'(k < 300), 1);
    chk("t5_pulses", nstart - n0, 6);
    chk("t5_queue_empty", exp_q.size(), 0);
    chk("t5_err_tmo", err_tmo, 0);

    // T6: reset during STORE, then a single-pair run
    tick();
    push_run(1);
    go(2, 2);
    k = 0;
    while (!res_we && k < 100) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    tick();
    chk("t6_start_qalc", start_qalc, 0);
    chk("t6_res_we", res_we, 0);
    chk("t6_res_addr", res_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_err_tmo", err_tmo, 0);
    reset = 1'b0;
    tick();
    push_run(1);
    n0 = nstart;
    go(1, 1);
    wait_done("t6b", 100);
    chk("t6b_pulses", nstart - n0, 1);
    chk("t6b_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
